// File: rtl/vx_rop_bus_receiver_pkg.sv
// VX_rop_pkg: shared types for the ROP request bus receiver.
//   rop_frag_t        : one fragment {pos_x, pos_y, color, depth, face}, pos_x in the MSBs.
//   rop_recv_state_e  : receiver FSM states (IDLE = holding register empty, DRAIN = lanes pending).
//   UUID_WIDTH, VX_ROP_DIM_BITS, VX_ROP_DEPTH_BITS : bus field widths.
package VX_rop_pkg;

  localparam int unsigned UUID_WIDTH        = 16;
  localparam int unsigned VX_ROP_DIM_BITS   = 11;
  localparam int unsigned VX_ROP_DEPTH_BITS = 24;

  typedef struct packed {
    logic [VX_ROP_DIM_BITS-1:0]   pos_x;
    logic [VX_ROP_DIM_BITS-1:0]   pos_y;
    logic [31:0]                  color;
    logic [VX_ROP_DEPTH_BITS-1:0] depth;
    logic                         face;
  } rop_frag_t;

  localparam int unsigned ROP_FRAG_BITS = $bits(rop_frag_t);

  typedef enum logic {
    ROP_RECV_IDLE  = 1'b0,
    ROP_RECV_DRAIN = 1'b1
  } rop_recv_state_e;

endpackage

// File: rtl/vx_rop_bus_receiver_lane_select.sv
// vx_rop_lane_select: combinational lowest-set-first lane picker.
//   i_rem_mask   : lanes still waiting to be issued
//   o_lane_idx   : lane index feeding each output slot (slot 0 = lowest lane)
//   o_slot_valid : slots carrying a fragment, contiguous ones from bit 0
//   o_issued     : lanes consumed by this beat
module vx_rop_lane_select #(
  parameter  int unsigned NUM_LANES = 4,
  parameter  int unsigned OUT_LANES = 1,
  localparam int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0]            i_rem_mask,
  output logic [OUT_LANES-1:0][IDX_W-1:0] o_lane_idx,
  output logic [OUT_LANES-1:0]            o_slot_valid,
  output logic [NUM_LANES-1:0]            o_issued
);

  always_comb begin
    int unsigned slot;
    o_lane_idx   = '0;
    o_slot_valid = '0;
    o_issued     = '0;
    slot         = 0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (i_rem_mask[l] && (slot < OUT_LANES)) begin
        o_lane_idx[slot]   = IDX_W'(l);
        o_slot_valid[slot] = 1'b1;
        o_issued[l]        = 1'b1;
        slot++;
      end
    end
  end

endmodule

// File: rtl/vx_rop_bus_receiver.sv
// vx_rop_bus_receiver: ROP-side end of the ROP request bus. Accepts one multi-lane
// request per handshake, holds it, and emits its active lanes as a compacted
// fragment stream, OUT_LANES fragments per beat. Zero-mask requests are dropped.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (req_ready depends on out_ready)
//   req_uuid/mask/pos_x/pos_y/color/depth/face : request payload, lane-packed LSB-first
//   out_valid/out_ready        : fragment beat handshake
//   out_mask                   : valid slots, contiguous from bit 0
//   out_frag                   : OUT_LANES packed rop_frag_t, slot 0 in the LSBs
//   out_uuid, out_eop          : source tag, last beat of the request
// Optional build macro VX_ROP_RECV_PERF_EN adds perf_frags, perf_stalls, perf_drops.
module vx_rop_bus_receiver
  import VX_rop_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned OUT_LANES = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [UUID_WIDTH-1:0]                  req_uuid,
  input  logic [NUM_LANES-1:0]                   req_mask,
  input  logic [NUM_LANES*VX_ROP_DIM_BITS-1:0]   req_pos_x,
  input  logic [NUM_LANES*VX_ROP_DIM_BITS-1:0]   req_pos_y,
  input  logic [NUM_LANES*32-1:0]                req_color,
  input  logic [NUM_LANES*VX_ROP_DEPTH_BITS-1:0] req_depth,
  input  logic [NUM_LANES-1:0]                   req_face,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_LANES-1:0]                   out_mask,
  output logic [OUT_LANES*ROP_FRAG_BITS-1:0]     out_frag,
  output logic [UUID_WIDTH-1:0]                  out_uuid,
  output logic                                   out_eop
`ifdef VX_ROP_RECV_PERF_EN
  ,
  output logic [31:0]                            perf_frags,
  output logic [31:0]                            perf_stalls,
  output logic [31:0]                            perf_drops
`endif
);

  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  rop_recv_state_e        r_state;
  logic [NUM_LANES-1:0]   r_rem_mask;
  logic [UUID_WIDTH-1:0]  r_uuid;
  rop_frag_t              r_frag [NUM_LANES];

  rop_frag_t                      w_req_frag [NUM_LANES];
  logic [OUT_LANES-1:0][IDX_W-1:0] w_lane_idx;
  logic [OUT_LANES-1:0]            w_slot_valid;
  logic [NUM_LANES-1:0]            w_issued;
  logic                            w_accept;
  logic                            w_load;
  logic                            w_drop;
  logic                            w_fire;

  vx_rop_lane_select #(
    .NUM_LANES (NUM_LANES),
    .OUT_LANES (OUT_LANES)
  ) u_lane_select (
    .i_rem_mask   (r_rem_mask),
    .o_lane_idx   (w_lane_idx),
    .o_slot_valid (w_slot_valid),
    .o_issued     (w_issued)
  );

  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      w_req_frag[l].pos_x = req_pos_x[l*VX_ROP_DIM_BITS +: VX_ROP_DIM_BITS];
      w_req_frag[l].pos_y = req_pos_y[l*VX_ROP_DIM_BITS +: VX_ROP_DIM_BITS];
      w_req_frag[l].color = req_color[l*32 +: 32];
      w_req_frag[l].depth = req_depth[l*VX_ROP_DEPTH_BITS +: VX_ROP_DEPTH_BITS];
      w_req_frag[l].face  = req_face[l];
    end
  end

  assign out_valid = (r_state == ROP_RECV_DRAIN);
  assign out_eop   = out_valid && ((r_rem_mask & ~w_issued) == '0);
  assign out_mask  = w_slot_valid;
  assign out_uuid  = r_uuid;
  // A new request may land in the same cycle the last beat of the current one leaves.
  assign req_ready = !reset && (!out_valid || (out_eop && out_ready));
  assign w_accept  = req_valid && req_ready;
  assign w_load    = w_accept && (req_mask != '0);
  assign w_drop    = w_accept && (req_mask == '0);
  assign w_fire    = out_valid && out_ready;

  always_comb begin
    out_frag = '0;
    for (int unsigned s = 0; s < OUT_LANES; s++) begin
      out_frag[s*ROP_FRAG_BITS +: ROP_FRAG_BITS] = r_frag[w_lane_idx[s]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ROP_RECV_IDLE;
      r_rem_mask <= '0;
    end else begin
      case (r_state)
        ROP_RECV_IDLE: begin
          if (w_load) begin
            r_state    <= ROP_RECV_DRAIN;
            r_rem_mask <= req_mask;
          end
        end
        ROP_RECV_DRAIN: begin
          if (w_fire) begin
            if (!out_eop) begin
              r_rem_mask <= r_rem_mask & ~w_issued;
            end else if (w_load) begin
              r_rem_mask <= req_mask;
            end else begin
              r_rem_mask <= '0;
              r_state    <= ROP_RECV_IDLE;
            end
          end
        end
        default: begin
          r_state    <= ROP_RECV_IDLE;
          r_rem_mask <= '0;
        end
      endcase
    end
  end

  // Payload is only meaningful while r_rem_mask is non-zero, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_uuid <= req_uuid;
      r_frag <= w_req_frag;
    end
  end

`ifdef VX_ROP_RECV_PERF_EN
  localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

  logic [CNT_W-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int unsigned s = 0; s < OUT_LANES; s++) begin
      w_pop = w_pop + CNT_W'(out_mask[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_frags  <= '0;
      perf_stalls <= '0;
      perf_drops  <= '0;
    end else begin
      if (w_fire)                  perf_frags  <= perf_frags + 32'(w_pop);
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
      if (w_drop)                  perf_drops  <= perf_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_rop_bus_receiver.sv
// Self-checking bench for vx_rop_bus_receiver: two instances (OUT_LANES=1 and 2),
// expected beats queued at request handshake and compared as beats fire.
module tb_vx_rop_bus_receiver;
  import VX_rop_pkg::*;

  localparam int FB = ROP_FRAG_BITS;
  localparam int DB = VX_ROP_DIM_BITS;
  localparam int ZB = VX_ROP_DEPTH_BITS;

  typedef struct packed {
    logic [1:0]            mask;
    logic [2*FB-1:0]       frag;
    logic [UUID_WIDTH-1:0] uuid;
    logic                  eop;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                  rv[2];
  logic                  rrdy[2];
  logic [UUID_WIDTH-1:0] ruuid[2];
  logic [3:0]            rmask[2];
  logic [4*DB-1:0]       rpx[2];
  logic [4*DB-1:0]       rpy[2];
  logic [127:0]          rcol[2];
  logic [4*ZB-1:0]       rdep[2];
  logic [3:0]            rface[2];
  logic                  ov[2];
  logic                  ordy[2];
  logic                  oeop[2];
  logic [UUID_WIDTH-1:0] ouuid[2];
  logic [0:0]            omask0;
  logic [1:0]            omask1;
  logic [FB-1:0]         ofrag0;
  logic [2*FB-1:0]       ofrag1;
`ifdef VX_ROP_RECV_PERF_EN
  logic [31:0] pf[2];
  logic [31:0] ps[2];
  logic [31:0] pd[2];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int nb[2];
  int exp_frags[2];

  always @(posedge clk) cyc <= cyc + 1;

  vx_rop_bus_receiver #(.NUM_LANES(4), .OUT_LANES(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rrdy[0]), .req_uuid(ruuid[0]), .req_mask(rmask[0]),
    .req_pos_x(rpx[0]), .req_pos_y(rpy[0]), .req_color(rcol[0]), .req_depth(rdep[0]),
    .req_face(rface[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_mask(omask0), .out_frag(ofrag0),
    .out_uuid(ouuid[0]), .out_eop(oeop[0])
`ifdef VX_ROP_RECV_PERF_EN
    , .perf_frags(pf[0]), .perf_stalls(ps[0]), .perf_drops(pd[0])
`endif
  );

  vx_rop_bus_receiver #(.NUM_LANES(4), .OUT_LANES(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rrdy[1]), .req_uuid(ruuid[1]), .req_mask(rmask[1]),
    .req_pos_x(rpx[1]), .req_pos_y(rpy[1]), .req_color(rcol[1]), .req_depth(rdep[1]),
    .req_face(rface[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_mask(omask1), .out_frag(ofrag1),
    .out_uuid(ouuid[1]), .out_eop(oeop[1])
`ifdef VX_ROP_RECV_PERF_EN
    , .perf_frags(pf[1]), .perf_stalls(ps[1]), .perf_drops(pd[1])
`endif
  );

  task automatic check(input string tag, input logic [2*FB-1:0] act, input logic [2*FB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Beat monitor / scoreboard pop
  always @(negedge clk) begin
    beat_t e;
    if (!reset && ov[0] && ordy[0]) begin
      nb[0]++;
      if (q0.size() == 0) check("d0_unexpected_beat", 1, 0);
      else begin
        e = q0.pop_front();
        check("d0_mask", omask0, e.mask);
        check("d0_frag", ofrag0, e.frag[FB-1:0]);
        check("d0_uuid", ouuid[0], e.uuid);
        check("d0_eop", oeop[0], e.eop);
      end
    end
    if (!reset && ov[1] && ordy[1]) begin
      nb[1]++;
      if (q1.size() == 0) check("d1_unexpected_beat", 1, 0);
      else begin
        e = q1.pop_front();
        check("d1_mask", omask1, e.mask);
        for (int s = 0; s < 2; s++)
          if (e.mask[s]) check("d1_frag", ofrag1[s*FB +: FB], e.frag[s*FB +: FB]);
        check("d1_uuid", ouuid[1], e.uuid);
        check("d1_eop", oeop[1], e.eop);
      end
    end
  end

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Called at #1 after a posedge; returns at #1 after the handshake edge.
  task automatic send(input int d, input logic [UUID_WIDTH-1:0] uuid, input logic [3:0] mask,
                      output int hs);
    logic [FB-1:0] lf[4];
    beat_t b;
    int ol, slot, seen, act_n;
    logic ok;
    ol = (d == 0) ? 1 : 2;
    ruuid[d] = uuid;
    rmask[d] = mask;
    act_n = 0;
    for (int l = 0; l < 4; l++) begin
      rpx[d][l*DB +: DB]  = DB'($urandom);
      rpy[d][l*DB +: DB]  = DB'($urandom);
      rcol[d][l*32 +: 32] = $urandom;
      rdep[d][l*ZB +: ZB] = ZB'($urandom);
      rface[d][l]         = 1'($urandom);
      lf[l] = {rpx[d][l*DB +: DB], rpy[d][l*DB +: DB], rcol[d][l*32 +: 32],
               rdep[d][l*ZB +: ZB], rface[d][l]};
      if (mask[l]) act_n++;
    end
    rv[d] = 1'b1;
    ok = 1'b0;
    hs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rrdy[d]) begin
        ok = 1'b1;
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("hs_timeout", 0, 1);
    else begin
      b = '0;
      slot = 0;
      seen = 0;
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) begin
          b.frag[slot*FB +: FB] = lf[l];
          b.mask[slot] = 1'b1;
          slot++;
          seen++;
          exp_frags[d]++;
          if (slot == ol || seen == act_n) begin
            b.uuid = uuid;
            b.eop  = (seen == act_n);
            if (d == 0) q0.push_back(b); else q1.push_back(b);
            b = '0;
            slot = 0;
          end
        end
      end
    end
    @(posedge clk); #1;
    rv[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (qsize(d) == 0) break;
    end
    check("drain_timeout", qsize(d), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ha, hb, h, nstart;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; ordy[d] = 1'b1; ruuid[d] = '0; rmask[d] = '0;
      rpx[d] = '0; rpy[d] = '0; rcol[d] = '0; rdep[d] = '0; rface[d] = '0;
      nb[d] = 0; exp_frags[d] = 0;
    end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", rrdy[0], 0);
    check("rst_out_valid", ov[0], 0);
    check("rst_out_eop", oeop[0], 0);
    check("rst_out_valid1", ov[1], 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", rrdy[0], 1);
    check("post_rst_out_valid", ov[0], 0);
    @(posedge clk); #1;

    // 1: sparse mask, single-slot beats
    nstart = nb[0];
    send(0, 16'h00A1, 4'b1011, h);
    wait_drain(0);
    check("t1_beats", nb[0] - nstart, 3);

    // 2: two-slot beats, full and single-lane masks
    nstart = nb[1];
    send(1, 16'h0B22, 4'b1111, h);
    wait_drain(1);
    check("t2_full_beats", nb[1] - nstart, 2);
    nstart = nb[1];
    send(1, 16'h0B23, 4'b0100, h);
    wait_drain(1);
    check("t2_single_beats", nb[1] - nstart, 1);

    // 3: zero-mask request is consumed with no beat
    send(0, 16'h0C00, 4'b0000, h);
    repeat (4) begin
      @(negedge clk);
      check("t3_no_valid", ov[0], 0);
    end
    @(posedge clk); #1;

    // 4: back-to-back, second request taken on the first's eop beat
    send(0, 16'h0D01, 4'b0011, ha);
    send(0, 16'h0D02, 4'b0101, hb);
    check("t4_b2b_gap_d0", hb - ha, 2);
    wait_drain(0);
    send(1, 16'h0D11, 4'b1111, ha);
    send(1, 16'h0D12, 4'b0001, hb);
    check("t4_b2b_gap_d1", hb - ha, 2);
    wait_drain(1);

    // 5: five-cycle stall mid-request
    send(0, 16'h0E05, 4'b1111, h);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t5_valid_held", ov[0], 1);
      check("t5_req_ready", rrdy[0], 0);
      if (q0.size() == 0) check("t5_queue_empty", 0, 1);
      else begin
        check("t5_frag_stable", ofrag0, q0[0].frag[FB-1:0]);
        check("t5_mask_stable", omask0, q0[0].mask);
        check("t5_eop_stable", oeop[0], q0[0].eop);
        check("t5_uuid_stable", ouuid[0], q0[0].uuid);
      end
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    wait_drain(0);

`ifdef VX_ROP_RECV_PERF_EN
    check("perf_drops0", pd[0], 1);
    check("perf_stalls0", ps[0], 5);
    check("perf_frags0", pf[0], exp_frags[0]);
    check("perf_drops1", pd[1], 0);
    check("perf_stalls1", ps[1], 0);
    check("perf_frags1", pf[1], exp_frags[1]);
`endif

    // 6: reset with two lanes still pending
    send(0, 16'h0F06, 4'b1111, h);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    ordy[0] = 1'b0;
    @(negedge clk);
    check("t6_req_ready_in_rst", rrdy[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ordy[0] = 1'b1;
    q0.delete();
    repeat (4) begin
      @(negedge clk);
      check("t6_no_valid", ov[0], 0);
      check("t6_no_eop", oeop[0], 0);
    end
    check("t6_req_ready", rrdy[0], 1);
    @(posedge clk); #1;
    nstart = nb[0];
    send(0, 16'h0F07, 4'b1000, h);
    wait_drain(0);
    check("t6_recover_beats", nb[0] - nstart, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
